// File: rtl/elevator_car.sv
// Clocked car/shaft plant: timed floor travel, timed door, floor-limit protection.
// Optional build macro CAR_DOOR_AUTOCLOSE_EN adds the dwell timeout and edge-triggered reopen.
module elevator_car #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 2,
  parameter int DWELL_CYCLES  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       door_open,
  input  logic [1:0] updown,
  output logic [2:0] floor,
  output logic       door,
  output logic       moving,
  output logic       cmd_err
);

  localparam int MAX_A   = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int MAX_CYC = (MAX_A > DWELL_CYCLES) ? MAX_A : DWELL_CYCLES;
  localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  localparam logic [2:0]    TOP        = 3'(NUM_FLOORS - 1);
  localparam logic [1:0]    CMD_UP     = 2'b01;
  localparam logic [1:0]    CMD_DN     = 2'b10;
  localparam logic [1:0]    CMD_ILL    = 2'b11;
  localparam logic [CW-1:0] TRAVEL_CNT = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_CNT   = CW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DN,
    OPENING,
    OPEN,
    CLOSING
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    floor_up;
  logic [2:0]    floor_dn;
  logic          door_req;

  assign floor_up = floor + 3'd1;
  assign floor_dn = floor - 3'd1;

`ifdef CAR_DOOR_AUTOCLOSE_EN
  localparam logic [CW-1:0] DWELL_CNT = CW'(DWELL_CYCLES - 1);
  logic door_open_q;

  // Opening needs a fresh press so a held button cannot defeat the dwell timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) door_open_q <= 1'b0;
    else        door_open_q <= door_open;
  end

  assign door_req = door_open & ~door_open_q;
`else
  assign door_req = door_open;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      floor   <= 3'd0;
      door    <= 1'b0;
      moving  <= 1'b0;
      cmd_err <= 1'b0;
      cnt     <= '0;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (updown == CMD_ILL) begin
            cmd_err <= 1'b1;
          end else if (door_req) begin
            state <= OPENING;
            cnt   <= DOOR_CNT;
          end else if (updown == CMD_UP) begin
            if (floor != TOP) begin
              state  <= MOVE_UP;
              moving <= 1'b1;
              cnt    <= TRAVEL_CNT;
            end else begin
              cmd_err <= 1'b1;
            end
          end else if (updown == CMD_DN) begin
            if (floor != 3'd0) begin
              state  <= MOVE_DN;
              moving <= 1'b1;
              cnt    <= TRAVEL_CNT;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end

        // A leg always runs to the next floor; only the continuation decision looks at updown.
        MOVE_UP: begin
          if (updown == CMD_ILL) cmd_err <= 1'b1;
          if (cnt == '0) begin
            floor <= floor_up;
            if (updown == CMD_UP && floor_up != TOP) begin
              cnt <= TRAVEL_CNT;
            end else begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        MOVE_DN: begin
          if (updown == CMD_ILL) cmd_err <= 1'b1;
          if (cnt == '0) begin
            floor <= floor_dn;
            if (updown == CMD_DN && floor_dn != 3'd0) begin
              cnt <= TRAVEL_CNT;
            end else begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        OPENING: begin
          if (cnt == '0) begin
            state <= OPEN;
            door  <= 1'b1;
`ifdef CAR_DOOR_AUTOCLOSE_EN
            cnt   <= DWELL_CNT;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        OPEN: begin
          if (!door_open) begin
            state <= CLOSING;
            door  <= 1'b0;
            cnt   <= DOOR_CNT;
          end
`ifdef CAR_DOOR_AUTOCLOSE_EN
          else if (cnt == '0) begin
            state <= CLOSING;
            door  <= 1'b0;
            cnt   <= DOOR_CNT;
          end else begin
            cnt <= cnt - 1'b1;
          end
`endif
        end

        // Safety reopen takes precedence over finishing the close.
        CLOSING: begin
          if (door_req) begin
            state <= OPENING;
            cnt   <= DOOR_CNT;
          end else if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          door   <= 1'b0;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_car.sv
// Directed bench for elevator_car: expected {floor,door,moving,cmd_err} are queued per step
// and popped after the following clock edge.
module tb_elevator_car;

  logic       clk;
  logic       rst_n;
  logic       door_open;
  logic [1:0] updown;
  logic [2:0] floor;
  logic       door;
  logic       moving;
  logic       cmd_err;

  typedef struct {
    string      tag;
    logic [5:0] vec;
  } exp_t;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  elevator_car dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .door_open(door_open),
    .updown   (updown),
    .floor    (floor),
    .door     (door),
    .moving   (moving),
    .cmd_err  (cmd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output();
    exp_t       e;
    logic [5:0] obs;
    obs = {floor, door, moving, cmd_err};
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: observed %b, required a queued expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.vec) else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed floor=%0d door=%b moving=%b cmd_err=%b, expected floor=%0d door=%b moving=%b cmd_err=%b",
               e.tag, obs[5:3], obs[2], obs[1], obs[0], e.vec[5:3], e.vec[2], e.vec[1], e.vec[0]);
      end
    end
  endtask

  task automatic expect_now(input logic [2:0] ef, input logic ed, input logic em,
                            input logic ee, input string tag);
    exp_t e;
    e.tag = tag;
    e.vec = {ef, ed, em, ee};
    sb.push_back(e);
    check_output();
  endtask

  // Drive one cycle of inputs, then check the outputs registered on the next edge.
  task automatic apply_stimulus(input logic d, input logic [1:0] u, input logic [2:0] ef,
                                input logic ed, input logic em, input logic ee, input string tag);
    exp_t e;
    door_open = d;
    updown    = u;
    e.tag = tag;
    e.vec = {ef, ed, em, ee};
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    door_open    = 1'b0;
    updown       = 2'b00;
    #3;
    expect_now(3'd0, 1'b0, 1'b0, 1'b0, "reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single leg 0 -> 1.
    apply_stimulus(1'b0, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0, "leg_entry");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, "leg_mid");
    apply_stimulus(1'b0, 2'b00, 3'd1, 1'b0, 1'b0, 1'b0, "leg_done");
    apply_stimulus(1'b0, 2'b00, 3'd1, 1'b0, 1'b0, 1'b0, "idle_hold");

    // Held up request runs back-to-back legs to the top floor.
    apply_stimulus(1'b0, 2'b01, 3'd1, 1'b0, 1'b1, 1'b0, "run_entry");
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 3; j++)
        apply_stimulus(1'b0, 2'b01, 3'(1 + i), 1'b0, 1'b1, 1'b0, "run_mid");
      apply_stimulus(1'b0, 2'b01, 3'(2 + i), 1'b0, (i < 5), 1'b0, "run_floor");
    end
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 2'b01, 3'd7, 1'b0, 1'b0, 1'b1, "top_limit_err");
    apply_stimulus(1'b0, 2'b00, 3'd7, 1'b0, 1'b0, 1'b0, "top_err_clear");

`ifndef CAR_DOOR_AUTOCLOSE_EN
    // Level-held door, motion requests ignored while open, safety reopen.
    for (int i = 0; i < 10; i++)
      apply_stimulus(1'b1, 2'b00, 3'd7, (i >= 2), 1'b0, 1'b0, "door_hold");
    apply_stimulus(1'b1, 2'b11, 3'd7, 1'b1, 1'b0, 1'b0, "door_ignore_ill");
    apply_stimulus(1'b1, 2'b10, 3'd7, 1'b1, 1'b0, 1'b0, "door_ignore_dn");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 2'b00, 3'd7, 1'b0, 1'b0, 1'b0, "door_close");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, 2'b00, 3'd7, (i == 2), 1'b0, 1'b0, "door_reopen_idle");
    apply_stimulus(1'b0, 2'b00, 3'd7, 1'b0, 1'b0, 1'b0, "closing_start");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, 2'b00, 3'd7, (i == 2), 1'b0, 1'b0, "safety_reopen");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 2'b00, 3'd7, 1'b0, 1'b0, 1'b0, "door_close2");
`else
    // Held button: open for exactly the dwell, close, and no reopen on the level.
    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b1, 2'b00, 3'd7, (i >= 2), 1'b0, 1'b0, "auto_open_dwell");
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'b1, 2'b00, 3'd7, 1'b0, 1'b0, 1'b0, "auto_no_level_reopen");
    apply_stimulus(1'b0, 2'b00, 3'd7, 1'b0, 1'b0, 1'b0, "auto_release");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, 2'b00, 3'd7, (i == 2), 1'b0, 1'b0, "auto_edge_reopen");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 2'b00, 3'd7, 1'b0, 1'b0, 1'b0, "auto_close");
`endif

    // Down from 7 to 3 with continuous legs, releasing during the last leg.
    apply_stimulus(1'b0, 2'b10, 3'd7, 1'b0, 1'b1, 1'b0, "down_entry");
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++)
        apply_stimulus(1'b0, (i == 3) ? 2'b00 : 2'b10, 3'(7 - i), 1'b0, 1'b1, 1'b0, "down_mid");
      apply_stimulus(1'b0, (i == 3) ? 2'b00 : 2'b10, 3'(6 - i), 1'b0, (i < 3), 1'b0, "down_floor");
    end

    // Leg 3 -> 4 with reversal and door pulses mid-leg.
    apply_stimulus(1'b0, 2'b01, 3'd3, 1'b0, 1'b1, 1'b0, "rev_entry");
    apply_stimulus(1'b1, 2'b10, 3'd3, 1'b0, 1'b1, 1'b0, "rev_mid_door");
    apply_stimulus(1'b0, 2'b10, 3'd3, 1'b0, 1'b1, 1'b0, "rev_mid");
    apply_stimulus(1'b1, 2'b10, 3'd3, 1'b0, 1'b1, 1'b0, "rev_mid_door2");
    apply_stimulus(1'b0, 2'b10, 3'd4, 1'b0, 1'b0, 1'b0, "rev_arrive");
    apply_stimulus(1'b0, 2'b10, 3'd4, 1'b0, 1'b1, 1'b0, "rev_down_entry");
    apply_stimulus(1'b0, 2'b00, 3'd4, 1'b0, 1'b1, 1'b0, "rev_down_mid");
    apply_stimulus(1'b0, 2'b11, 3'd4, 1'b0, 1'b1, 1'b1, "midleg_ill_err");
    apply_stimulus(1'b0, 2'b00, 3'd4, 1'b0, 1'b1, 1'b0, "midleg_after_err");
    apply_stimulus(1'b0, 2'b00, 3'd3, 1'b0, 1'b0, 1'b0, "rev_down_arrive");

    // Down to floor 2, then reset two cycles into an up leg.
    apply_stimulus(1'b0, 2'b10, 3'd3, 1'b0, 1'b1, 1'b0, "to2_entry");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 2'b00, 3'd3, 1'b0, 1'b1, 1'b0, "to2_mid");
    apply_stimulus(1'b0, 2'b00, 3'd2, 1'b0, 1'b0, 1'b0, "to2_arrive");
    apply_stimulus(1'b0, 2'b01, 3'd2, 1'b0, 1'b1, 1'b0, "rst_leg_entry");
    apply_stimulus(1'b0, 2'b00, 3'd2, 1'b0, 1'b1, 1'b0, "rst_leg_mid1");
    apply_stimulus(1'b0, 2'b00, 3'd2, 1'b0, 1'b1, 1'b0, "rst_leg_mid2");
    rst_n = 1'b0;
    #1;
    expect_now(3'd0, 1'b0, 1'b0, 1'b0, "async_reset");
    apply_stimulus(1'b0, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, "reset_held");
    rst_n = 1'b1;

    // Illegal and out-of-range commands at floor 0.
    apply_stimulus(1'b0, 2'b11, 3'd0, 1'b0, 1'b0, 1'b1, "idle_ill_err");
    apply_stimulus(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, "idle_err_clear");
    apply_stimulus(1'b0, 2'b10, 3'd0, 1'b0, 1'b0, 1'b1, "bottom_limit_err");
    apply_stimulus(1'b1, 2'b11, 3'd0, 1'b0, 1'b0, 1'b1, "ill_beats_door");
    apply_stimulus(1'b0, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0, "post_reset_leg");

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_leftover: observed %0d entries, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/elevator_car.md
Name: elevator_car

Overview:
- Cycle-accurate car/shaft responder driven by the mover's command pair (door_open, updown); reports floor and door state back to it.
- Replaces the untimed car model with a clocked plant: finite travel time per floor, finite door operating time, floor-limit protection.
- Sits under mover; its door output is the rising-edge event the controller uses to board and alight passengers.

Parameters:
- NUM_FLOORS, 8, number of floors (2..8); floor range 0..NUM_FLOORS-1.
- TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1).
- DOOR_CYCLES, 2, clock cycles for the door to fully open or fully close (>=1).
- DWELL_CYCLES, 6, open dwell before auto-close (used only with CAR_DOOR_AUTOCLOSE_EN).

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- door_open  input  1  level request: 1 = open/hold door open, 0 = close.
- updown  input  2  01 = move up, 10 = move down, 00 = hold, 11 = illegal.
- floor  output  3  current floor; changes only on leg completion.
- door  output  1  1 only while door fully open.
- moving  output  1  1 while a travel leg is in progress.
- cmd_err  output  1  one-cycle pulse on rejected command.

Behaviour:
- Reset (async, rst_n=0): state IDLE, floor=0, door=0, moving=0, cmd_err=0, all counters 0. Reset mid-leg or mid-door abandons the operation; floor returns to 0.
- States: IDLE, MOVE_UP, MOVE_DN, OPENING, OPEN, CLOSING. Registered outputs; single down-counter wide enough for max(TRAVEL_CYCLES, DOOR_CYCLES, DWELL_CYCLES).
- IDLE, priority order:
  - updown=11 -> cmd_err pulse, stay.
  - door_open=1 -> OPENING. Door has priority over motion.
  - updown=01 with floor<NUM_FLOORS-1 -> MOVE_UP.
  - updown=01 at top floor -> cmd_err pulse, stay.
  - updown=10 with floor>0 -> MOVE_DN.
  - updown=10 at floor 0 -> cmd_err pulse, stay.
- MOVE_UP/MOVE_DN:
  - moving=1 from the entry edge.
  - Leg entered on edge k; floor updates by +/-1 on edge k+TRAVEL_CYCLES.
  - On that same edge: if updown still requests the same direction and the new floor is not the limit, start the next leg with no idle cycle. Otherwise go to IDLE with moving=0.
  - Reversal, hold or door_open mid-leg is ignored until leg end; the car never stops between floors.
  - updown=11 mid-leg: cmd_err pulse, leg completes normally.
- OPENING: DOOR_CYCLES cycles, then OPEN with door=1 on the same edge.
- OPEN: door=1. door_open=0 -> CLOSING; door drops to 0 on that edge.
- CLOSING: DOOR_CYCLES cycles, then IDLE. door_open=1 during CLOSING -> OPENING with a fresh count (safety reopen).
- updown nonzero in OPENING/OPEN/CLOSING: ignored, no cmd_err; it is re-evaluated once IDLE is reached.
- door and moving are never both 1. floor never leaves 0..NUM_FLOORS-1 and never wraps.

Optional Feature:
- CAR_DOOR_AUTOCLOSE_EN defined:
  - OPEN lasts at most DWELL_CYCLES, then goes to CLOSING even if door_open stays 1.
  - Reopening from IDLE or CLOSING needs a 0->1 edge on door_open (registered edge detect). A held level does not reopen.
- Not defined: OPEN persists while door_open=1; level-sensitive reopen; DWELL_CYCLES unused.

Test Plan:
- Reset, then updown=01 for one cycle from floor 0 -> moving=1 next edge, floor=1 exactly 4 cycles after entry, then IDLE with moving=0.
- Hold updown=01 from floor 5 -> floor 6 and 7 at 4-cycle spacing with no idle gap. Then cmd_err pulses once per cycle while updown=01 is held at floor 7; floor stays 7.
- In IDLE, assert door_open=1 for 10 cycles -> door=1 after 2 cycles, stays 1. Deassert -> door=0 next edge, IDLE 2 cycles later. Reassert door_open during CLOSING -> door=1 again 2 cycles later.
- Mid-leg from 3 to 4, switch updown to 10 and pulse door_open -> floor still reaches 4 on schedule, then MOVE_DN toward 3. No door activity during travel; door and moving never both 1.
- Assert rst_n=0 two cycles into a leg from floor 2 -> floor=0, moving=0, door=0 immediately (asynchronous). updown=11 in IDLE -> single cmd_err pulse, no state change.
- With CAR_DOOR_AUTOCLOSE_EN and door_open held at 1 -> door=1 for exactly 6 cycles, closes, no reopen until door_open goes 0 then 1.
